branch_event_counters: RTL and testbench

Parametrised multi-channel event counter bank for branch-predictor evaluation. It is the successor to the single 16-bit miss counter. It counts up to NUM_CH independent event streams, such as branches, mispredictions and BTB misses, with selectable wrap or saturate behaviour and sticky overflow flags. It also provides a snapshot bank, either manual or periodic, read back through an indexed, registered read port. It sits beside the pipeline's branch-resolution stage and is read by the test harness.

---
 rtl/branch_event_counters_pkg.sv | 33 +++
 rtl/event_counter_channel.sv | 59 +++++
 rtl/branch_event_counters.sv | 151 +++++++++++++++
 tb/tb_branch_event_counters.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_event_counters_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : branch_event_counters_pkg
//  Purpose  : Shared constants for the branch-predictor event counter bank:
//             counting modes, readback select width and the channel map used
//             by the branch-resolution stage.
//  Revision : 1.0 - initial release
// ============================================================================
package branch_event_counters_pkg;

    // Counting behaviour when a live counter is at its maximum value
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Readback index width; covers up to 16 channels
    localparam int RD_SEL_W = 4;

    // Channel assignments used by the pipeline
    localparam int CH_BRANCH   = 0;
    localparam int CH_MISPRED  = 1;
    localparam int CH_BTB_MISS = 2;
    localparam int CH_FLUSH    = 3;

    // Bits needed by a timer that counts 0..window-1 (at least one bit)
    function automatic int timer_width(input int window);
        if (window < 2) begin
            return 1;
        end
        return $clog2(window);
    endfunction

endpackage
`default_nettype wire

// File: rtl/event_counter_channel.sv
`default_nettype none
// ============================================================================
//  Module   : event_counter_channel
//  Purpose  : One live event counter with a sticky overflow flag. Clear wins
//             over a window restart, which wins over a plain increment.
//  Revision : 1.0 - initial release
// ============================================================================
module event_counter_channel
    import branch_event_counters_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             restart,
    output logic [WIDTH-1:0] o_count,
    output logic             o_overflow
);

    localparam logic [WIDTH-1:0] c_max = '1;
    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_overflow;

    // Live count and sticky overflow; a restart reloads with the current event
    // so an event landing on the window boundary is counted in the new window
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (restart) begin
            r_count    <= inc ? c_one : '0;
            r_overflow <= 1'b0;
        end else if (inc) begin
            if (r_count == c_max) begin
                r_overflow <= 1'b1;
                if (SATURATE == MODE_SAT) begin
                    r_count <= c_max;
                end else begin
                    r_count <= '0;
                end
            end else begin
                r_count <= r_count + c_one;
            end
        end
    end

    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/branch_event_counters.sv
`default_nettype none
// ============================================================================
//  Module   : branch_event_counters
//  Purpose  : Multi-channel event counter bank for branch-predictor
//             evaluation. Live counters with wrap/saturate and sticky
//             overflow, a snapshot bank filled by a manual request or by a
//             periodic window, and a registered indexed readback port.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_event_counters
    import branch_event_counters_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NUM_CH   = 4,
    parameter int SATURATE = MODE_WRAP,
    parameter int WINDOW   = 0
) (
    input  logic                CLOCK,
    input  logic                INIT,
    input  logic                ENABLE,
    input  logic [NUM_CH-1:0]   EVENT,
    input  logic [NUM_CH-1:0]   CLEAR,
    input  logic                SNAP,
    input  logic [RD_SEL_W-1:0] RD_SEL,
    output logic [WIDTH-1:0]    RD_DATA,
    output logic                RD_OVF,
    output logic                SNAP_VALID,
    output logic [NUM_CH-1:0]   OVERFLOW
);

    logic               w_expire;
    logic               w_trigger;
    logic [WIDTH-1:0]   w_count [NUM_CH];
    logic [NUM_CH-1:0]  w_ovf;

    logic [WIDTH-1:0]   r_snap [NUM_CH];
    logic [NUM_CH-1:0]  r_snap_ovf;
    logic               r_snap_valid;
    logic [WIDTH-1:0]   r_rd_data;
    logic               r_rd_ovf;

    logic [WIDTH-1:0]   w_rd_data;
    logic               w_rd_ovf;

    // ------------------------------------------------------------------------
    // Window timer: free-runs 0..WINDOW-1 regardless of ENABLE; the cycle it
    // sits at WINDOW-1 is the expiry that snapshots and restarts the counters
    // ------------------------------------------------------------------------
    generate
        if (WINDOW > 0) begin : g_window
            localparam int             c_tw   = timer_width(WINDOW);
            localparam logic [c_tw-1:0] c_last = c_tw'(WINDOW - 1);
            localparam logic [c_tw-1:0] c_one  = c_tw'(1);

            logic [c_tw-1:0] r_timer;

            // Advance the window timer, wrapping at the expiry cycle
            always_ff @(posedge CLOCK) begin
                if (INIT) begin
                    r_timer <= '0;
                end else if (r_timer == c_last) begin
                    r_timer <= '0;
                end else begin
                    r_timer <= r_timer + c_one;
                end
            end

            assign w_expire = (r_timer == c_last);
        end else begin : g_no_window
            assign w_expire = 1'b0;
        end
    endgenerate

    // A manual request coinciding with expiry is still one capture
    assign w_trigger = SNAP | w_expire;

    // ------------------------------------------------------------------------
    // Live counter channels
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            event_counter_channel #(
                .WIDTH    (WIDTH),
                .SATURATE (SATURATE)
            ) u_channel (
                .clk        (CLOCK),
                .rst        (INIT),
                .inc        (ENABLE & EVENT[i]),
                .clr        (CLEAR[i]),
                .restart    (w_expire),
                .o_count    (w_count[i]),
                .o_overflow (w_ovf[i])
            );
        end
    endgenerate

    assign OVERFLOW = w_ovf;

    // Snapshot bank captures the pre-update live state of every channel
    always_ff @(posedge CLOCK) begin
        if (INIT) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_snap[i] <= '0;
            end
            r_snap_ovf <= '0;
        end else if (w_trigger) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_snap[i] <= w_count[i];
            end
            r_snap_ovf <= w_ovf;
        end
    end

    // Capture notification, high for the single cycle after the capture edge
    always_ff @(posedge CLOCK) begin
        if (INIT) begin
            r_snap_valid <= 1'b0;
        end else begin
            r_snap_valid <= w_trigger;
        end
    end

    // Read mux; any index with no channel behind it reads as zero
    always_comb begin
        w_rd_data = '0;
        w_rd_ovf  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (RD_SEL == RD_SEL_W'(i)) begin
                w_rd_data = r_snap[i];
                w_rd_ovf  = r_snap_ovf[i];
            end
        end
    end

    // Registered readback, one cycle behind RD_SEL
    always_ff @(posedge CLOCK) begin
        if (INIT) begin
            r_rd_data <= '0;
            r_rd_ovf  <= 1'b0;
        end else begin
            r_rd_data <= w_rd_data;
            r_rd_ovf  <= w_rd_ovf;
        end
    end

    assign RD_DATA    = r_rd_data;
    assign RD_OVF     = r_rd_ovf;
    assign SNAP_VALID = r_snap_valid;

endmodule
`default_nettype wire

// File: tb/tb_branch_event_counters.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_event_counters
//  Purpose  : Self-checking bench for branch_event_counters. Three instances
//             share one stimulus stream: 4-bit wrap, 4-bit saturate and an
//             8-bit counter with an 8-cycle window.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_event_counters;

    logic       CLOCK = 1'b0;
    logic       INIT;
    logic       ENABLE;
    logic [3:0] EVENT;
    logic [3:0] CLEAR;
    logic       SNAP;
    logic [3:0] RD_SEL;

    logic [3:0] rd_wrap, rd_sat;
    logic [7:0] rd_win;
    logic       rdovf_wrap, rdovf_sat, rdovf_win;
    logic       sv_wrap, sv_sat, sv_win;
    logic [3:0] ovf_wrap, ovf_sat, ovf_win;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLOCK = ~CLOCK;

    branch_event_counters #(.WIDTH(4), .NUM_CH(4), .SATURATE(0), .WINDOW(0)) u_wrap (
        .CLOCK(CLOCK), .INIT(INIT), .ENABLE(ENABLE), .EVENT(EVENT), .CLEAR(CLEAR),
        .SNAP(SNAP), .RD_SEL(RD_SEL), .RD_DATA(rd_wrap), .RD_OVF(rdovf_wrap),
        .SNAP_VALID(sv_wrap), .OVERFLOW(ovf_wrap));

    branch_event_counters #(.WIDTH(4), .NUM_CH(4), .SATURATE(1), .WINDOW(0)) u_sat (
        .CLOCK(CLOCK), .INIT(INIT), .ENABLE(ENABLE), .EVENT(EVENT), .CLEAR(CLEAR),
        .SNAP(SNAP), .RD_SEL(RD_SEL), .RD_DATA(rd_sat), .RD_OVF(rdovf_sat),
        .SNAP_VALID(sv_sat), .OVERFLOW(ovf_sat));

    branch_event_counters #(.WIDTH(8), .NUM_CH(4), .SATURATE(0), .WINDOW(8)) u_win (
        .CLOCK(CLOCK), .INIT(INIT), .ENABLE(ENABLE), .EVENT(EVENT), .CLEAR(CLEAR),
        .SNAP(SNAP), .RD_SEL(RD_SEL), .RD_DATA(rd_win), .RD_OVF(rdovf_win),
        .SNAP_VALID(sv_win), .OVERFLOW(ovf_win));

    // Instance properties for the model
    function automatic int pw(input int d);
        return (d == 2) ? 8 : 4;
    endfunction
    function automatic int psat(input int d);
        return (d == 1) ? 1 : 0;
    endfunction
    function automatic int pwin(input int d);
        return (d == 2) ? 8 : 0;
    endfunction

    // Model state, indexed [instance][channel]
    int m_cnt   [3][4];
    int m_ovf   [3][4];
    int m_snap  [3][4];
    int m_snovf [3][4];
    int m_timer [3];
    int m_rd    [3];
    int m_rdovf [3];
    int m_sv    [3];
    bit m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one call per rising edge with the inputs present there
    task automatic model_step();
        int  mx;
        bit  expire;
        bit  trig;
        bit  inc;
        for (int d = 0; d < 3; d++) begin
            if (INIT) begin
                for (int c = 0; c < 4; c++) begin
                    m_cnt[d][c] = 0; m_ovf[d][c] = 0; m_snap[d][c] = 0; m_snovf[d][c] = 0;
                end
                m_timer[d] = 0; m_rd[d] = 0; m_rdovf[d] = 0; m_sv[d] = 0;
            end else begin
                mx     = (1 << pw(d)) - 1;
                expire = (pwin(d) > 0) && (m_timer[d] == pwin(d) - 1);
                trig   = SNAP || expire;
                // readback sees the bank as it was before this edge
                m_rd[d]    = (RD_SEL < 4) ? m_snap[d][RD_SEL] : 0;
                m_rdovf[d] = (RD_SEL < 4) ? m_snovf[d][RD_SEL] : 0;
                if (trig) begin
                    for (int c = 0; c < 4; c++) begin
                        m_snap[d][c]  = m_cnt[d][c];
                        m_snovf[d][c] = m_ovf[d][c];
                    end
                end
                m_sv[d] = trig ? 1 : 0;
                for (int c = 0; c < 4; c++) begin
                    inc = ENABLE && EVENT[c];
                    if (CLEAR[c]) begin
                        m_cnt[d][c] = 0; m_ovf[d][c] = 0;
                    end else if (expire) begin
                        m_cnt[d][c] = inc ? 1 : 0; m_ovf[d][c] = 0;
                    end else if (inc) begin
                        if (m_cnt[d][c] == mx) begin
                            m_ovf[d][c] = 1;
                            m_cnt[d][c] = psat(d) ? mx : 0;
                        end else begin
                            m_cnt[d][c] = m_cnt[d][c] + 1;
                        end
                    end
                end
                m_timer[d] = (pwin(d) > 0) ? (expire ? 0 : m_timer[d] + 1) : 0;
            end
        end
        if (INIT) m_valid = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge CLOCK);
            model_step();
        end
    end

    // Compare every instance against the model on each falling edge
    initial begin
        logic [7:0] a_rd;
        logic       a_rdovf, a_sv;
        logic [3:0] a_ovf, e_ovf;
        forever begin
            @(negedge CLOCK);
            if (m_valid) begin
                for (int d = 0; d < 3; d++) begin
                    case (d)
                        0:       begin a_rd = {4'b0, rd_wrap}; a_rdovf = rdovf_wrap; a_sv = sv_wrap; a_ovf = ovf_wrap; end
                        1:       begin a_rd = {4'b0, rd_sat};  a_rdovf = rdovf_sat;  a_sv = sv_sat;  a_ovf = ovf_sat;  end
                        default: begin a_rd = rd_win;          a_rdovf = rdovf_win;  a_sv = sv_win;  a_ovf = ovf_win;  end
                    endcase
                    for (int c = 0; c < 4; c++) e_ovf[c] = (m_ovf[d][c] != 0);
                    chk($sformatf("model d%0d RD_DATA", d), a_rd, m_rd[d]);
                    chk($sformatf("model d%0d RD_OVF", d), a_rdovf, m_rdovf[d]);
                    chk($sformatf("model d%0d SNAP_VALID", d), a_sv, m_sv[d]);
                    chk($sformatf("model d%0d OVERFLOW", d), a_ovf, e_ovf);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic snap_pulse();
        SNAP = 1'b1;
        step();
        SNAP = 1'b0;
    endtask

    // Directed stimulus with hand-computed expectations
    initial begin
        logic [3:0] exp_sweep [4];
        logic       exp_sweep_ovf [4];
        INIT = 1'b1; ENABLE = 1'b0; EVENT = '0; CLEAR = '0; SNAP = 1'b0; RD_SEL = '0;
        repeat (3) step();
        chk("reset wrap RD_DATA", rd_wrap, 0);
        chk("reset sat RD_OVF", rdovf_sat, 0);
        chk("reset win SNAP_VALID", sv_win, 0);
        chk("reset win OVERFLOW", ovf_win, 0);
        INIT = 1'b0;

        // Wrap mode: 17 events on channel 0
        ENABLE = 1'b1; EVENT = 4'b0001;
        repeat (17) step();
        EVENT = '0;
        chk("wrap OVERFLOW0 before snap", ovf_wrap[0], 1);
        RD_SEL = 4'd0;
        snap_pulse();
        chk("wrap SNAP_VALID pulse", sv_wrap, 1);
        step();
        chk("wrap SNAP_VALID drop", sv_wrap, 0);
        chk("wrap snap ch0", rd_wrap, 1);
        chk("wrap snap ovf0", rdovf_wrap, 1);
        chk("wrap OVERFLOW0 after snap", ovf_wrap[0], 1);
        chk("sat snap ch0", rd_sat, 15);

        // Saturate mode: 20 events on channel 1, then clear with a coincident event
        EVENT = 4'b0010;
        repeat (20) step();
        EVENT = '0;
        chk("sat OVERFLOW1", ovf_sat[1], 1);
        RD_SEL = 4'd1;
        snap_pulse();
        step();
        chk("sat held at max", rd_sat, 15);
        chk("sat snap ovf1", rdovf_sat, 1);
        chk("wrap ch1 after 20", rd_wrap, 4);
        CLEAR = 4'b0010; EVENT = 4'b0010;
        step();
        CLEAR = '0; EVENT = '0;
        chk("sat clear OVERFLOW1", ovf_sat[1], 0);
        chk("wrap clear OVERFLOW1", ovf_wrap[1], 0);
        snap_pulse();
        step();
        chk("sat clear count", rd_sat, 0);
        chk("sat clear snap ovf", rdovf_sat, 0);

        // Snapshot and event on the same cycle
        EVENT = 4'b0100;
        repeat (5) step();
        SNAP = 1'b1; RD_SEL = 4'd2;
        step();
        SNAP = 1'b0; EVENT = '0;
        chk("snap+event SNAP_VALID", sv_wrap, 1);
        step();
        chk("snap+event SNAP_VALID one cycle", sv_wrap, 0);
        chk("snap+event snapshot", rd_wrap, 5);
        snap_pulse();
        step();
        chk("snap+event live", rd_wrap, 6);

        // Readback: out-of-range select, then a back-to-back sweep
        RD_SEL = 4'd7;
        step();
        chk("rd_sel 7 data", rd_wrap, 0);
        chk("rd_sel 7 ovf", rdovf_wrap, 0);
        exp_sweep[0] = 4'd1; exp_sweep[1] = 4'd0; exp_sweep[2] = 4'd6; exp_sweep[3] = 4'd0;
        exp_sweep_ovf[0] = 1'b1; exp_sweep_ovf[1] = 1'b0; exp_sweep_ovf[2] = 1'b0; exp_sweep_ovf[3] = 1'b0;
        for (int s = 0; s < 4; s++) begin
            RD_SEL = 4'(s);
            step();
            chk($sformatf("sweep data ch%0d", s), rd_wrap, exp_sweep[s]);
            chk($sformatf("sweep ovf ch%0d", s), rdovf_wrap, exp_sweep_ovf[s]);
        end

        // Window mode: event held high from the first cycle after INIT
        INIT = 1'b1; ENABLE = 1'b0; EVENT = '0;
        repeat (2) step();
        INIT = 1'b0; ENABLE = 1'b1; EVENT = 4'b0001; RD_SEL = 4'd0;
        for (int e = 1; e <= 40; e++) begin
            step();
            chk($sformatf("window SNAP_VALID edge %0d", e), sv_win, (e % 8 == 0) ? 1 : 0);
            if ((e % 8 == 1) && (e > 1)) begin
                chk($sformatf("window snapshot edge %0d", e), rd_win, (e == 9) ? 7 : 8);
            end
        end

        // INIT in the middle of a window with nonzero counts
        repeat (5) step();
        INIT = 1'b1;
        step();
        chk("mid init RD_DATA", rd_win, 0);
        chk("mid init RD_OVF", rdovf_win, 0);
        chk("mid init SNAP_VALID", sv_win, 0);
        chk("mid init OVERFLOW", ovf_win, 0);
        chk("mid init wrap OVERFLOW", ovf_wrap, 0);
        INIT = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk($sformatf("post init SNAP_VALID edge %0d", e), sv_win, (e == 8) ? 1 : 0);
        end
        step();
        chk("post init snapshot", rd_win, 7);

        EVENT = '0; ENABLE = 1'b0;
        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
